// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronizer + 3-sample majority filter, framing FSM,
// and a first-word-fall-through receive FIFO with frame/overrun error pulses.
module uart_rx_cfg #(
    parameter int DIVISOR    = 10417,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_serial_in,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rx_perr,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            frame_err,
    output logic                            overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] HALF_CNT  = 16'(DIVISOR / 2);
    localparam logic [15:0] LAST_CNT  = 16'(DIVISOR - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic        ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_t;

    typedef struct packed {
        logic                 perr;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    // ---------------- input conditioning ----------------
    logic       sync1, sync2;
    logic [2:0] hist;
    logic       maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= rx_serial_in;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    // ---------------- framing FSM ----------------
    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           bit_idx, idx_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 perr, perr_n;
    logic                 push, ferr_n;
    logic                 at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            shreg     <= sh_n;
            perr      <= perr_n;
            frame_err <= ferr_n;
        end
    end

    assign at_end = (cnt == LAST_CNT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = bit_idx;
        sh_n    = shreg;
        perr_n  = perr;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                perr_n = 1'b0;
                if (!sync2) state_n = ST_START;
            end
            ST_START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    state_n = maj ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end) begin
                    cnt_n = '0;
                    sh_n  = {maj, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_n = bit_idx + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_end) begin
                    cnt_n   = '0;
                    perr_n  = (^shreg) ^ maj ^ ODD_PAR;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_end) begin
                    cnt_n = '0;
                    if (!maj) begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end else if (bit_idx == LAST_STOP) begin
                        push    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n = bit_idx + 4'd1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A break keeps us here, so it reports only one frame error
                cnt_n = '0;
                if (sync2) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------- receive FIFO ----------------
    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            pop, full, push_ok;

    assign pop     = rx_valid & rx_ready;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{perr: perr, data: shreg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= push & ~push_ok;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is masked while empty so the outputs read zero out of reset
    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? head.data : '0;
    assign rx_perr    = rx_valid & head.perr;
    assign fifo_count = count;

endmodule
